// File: rtl/random_delay_timer.sv
// random_delay_timer: arms a random MIN_TICKS..MIN_TICKS+2^RANGE_BITS-1 tick delay from the LFSR word.
// Optional EARLY_PRESS_EN adds press/early and a FOUL state for presses during the wait.
module random_delay_timer #(
   parameter int CLK_PER_TICK = 50000,
   parameter int MIN_TICKS    = 1000,
   parameter int RANGE_BITS   = 12
) (
   input  logic        clk,
   input  logic        reset,
`ifdef EARLY_PRESS_EN
   input  logic        press,
   output logic        early,
`endif
   input  logic [15:0] rnd,
   output logic        lfsr_ld,
   input  logic        start,
   input  logic        cancel,
   output logic        busy,
   output logic        expired,
   output logic [16:0] delay_val
);
   typedef enum logic [1:0] {IDLE, RUN, DONE, FOUL} state_t;
   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d, rnd_m;
   logic [16:0] rem_q, rem_d, dly_q, dly_d, dly_new;
   logic        busy_q, busy_d, exp_q, exp_d, ld_q, ld_d, wrap;
`ifdef EARLY_PRESS_EN
   logic        early_q, early_d;
`endif
   always_comb begin
      rnd_m   = rnd & 16'((1 << RANGE_BITS) - 1);
      dly_new = 17'(MIN_TICKS) + {1'b0, rnd_m};
      wrap    = presc_q == 16'(CLK_PER_TICK - 1);
      state_d = state_q;
      presc_d = presc_q;
      rem_d   = rem_q;
      dly_d   = dly_q;
      case (state_q)
         IDLE, DONE: state_d = cancel ? IDLE : start ? RUN : state_q;
         RUN: begin
            presc_d = wrap ? 16'd0 : presc_q + 16'd1;
            rem_d   = wrap ? rem_q - 17'd1 : rem_q;
`ifdef EARLY_PRESS_EN
            state_d = cancel ? IDLE : press ? FOUL : (wrap && rem_q == 17'd1) ? DONE : RUN;
`else
            state_d = cancel ? IDLE : (wrap && rem_q == 17'd1) ? DONE : RUN;
`endif
         end
         default: state_d = cancel ? IDLE : state_q;
      endcase
      // arming reloads the countdown from the rnd word seen at this edge only
      if ((state_q == IDLE || state_q == DONE) && start && !cancel) begin
         presc_d = 16'd0;
         rem_d   = dly_new;
         dly_d   = dly_new;
      end
      busy_d  = state_d == RUN;
      exp_d   = state_d == DONE;
      ld_d    = state_d == IDLE;
`ifdef EARLY_PRESS_EN
      early_d = state_d == FOUL;
`endif
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         presc_q <= 16'd0;
         rem_q   <= 17'd0;
         dly_q   <= 17'd0;
         busy_q  <= 1'b0;
         exp_q   <= 1'b0;
         ld_q    <= 1'b0;
`ifdef EARLY_PRESS_EN
         early_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         rem_q   <= rem_d;
         dly_q   <= dly_d;
         busy_q  <= busy_d;
         exp_q   <= exp_d;
         ld_q    <= ld_d;
`ifdef EARLY_PRESS_EN
         early_q <= early_d;
`endif
      end
   end
   assign busy      = busy_q;
   assign expired   = exp_q;
   assign lfsr_ld   = ld_q;
   assign delay_val = dly_q;
`ifdef EARLY_PRESS_EN
   assign early     = early_q;
`endif
endmodule

// File: tb/tb_random_delay_timer.sv
// tb_random_delay_timer: deadline-based reference model, vector table and directed latency checks.
module tb_random_delay_timer;
   localparam int C = 4, M = 2, R = 12;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0;
   logic [15:0] rnd = 16'd0;
   logic        lfsr_ld, busy, expired;
   logic [16:0] delay_val;
`ifdef EARLY_PRESS_EN
   logic        press = 1'b0, early;
`endif
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   random_delay_timer #(.CLK_PER_TICK(C), .MIN_TICKS(M), .RANGE_BITS(R)) dut (
      .clk(clk), .reset(reset),
`ifdef EARLY_PRESS_EN
      .press(press), .early(early),
`endif
      .rnd(rnd), .lfsr_ld(lfsr_ld), .start(start), .cancel(cancel),
      .busy(busy), .expired(expired), .delay_val(delay_val));
   typedef enum {M_RST, M_IDLE, M_RUN, M_DONE, M_FOUL} mst_t;
   mst_t   ms = M_RST;
   longint cyc = 0, deadline = 0;
   int     mdelay = 0;
   typedef struct {logic st; logic cn; logic [15:0] r; logic b; logic e; logic l; logic [16:0] dv;} vec_t;
   vec_t tv[10];
   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic arm_m();
      mdelay   = M + (int'(rnd) % (1 << R));
      deadline = cyc + longint'(mdelay * C);
      ms       = M_RUN;
   endtask
   task automatic model_edge();
      cyc++;
      case (ms)
         M_RST, M_IDLE: if (!cancel && start) arm_m(); else ms = M_IDLE;
         M_RUN: begin
            if (cancel) ms = M_IDLE;
`ifdef EARLY_PRESS_EN
            else if (press) ms = M_FOUL;
`endif
            else if (cyc == deadline) ms = M_DONE;
         end
         M_DONE: if (cancel) ms = M_IDLE; else if (start) arm_m();
         default: if (cancel) ms = M_IDLE;
      endcase
   endtask
   task automatic check_outs();
      chk("busy", 17'(busy), 17'(ms == M_RUN));
      chk("expired", 17'(expired), 17'(ms == M_DONE));
      chk("lfsr_ld", 17'(lfsr_ld), 17'(ms == M_IDLE));
      chk("delay_val", delay_val, 17'(mdelay));
`ifdef EARLY_PRESS_EN
      chk("early", 17'(early), 17'(ms == M_FOUL));
`endif
   endtask
   task automatic tick(input logic st, input logic cn, input logic [15:0] r);
      start = st; cancel = cn; rnd = r;
      @(posedge clk); #1;
      if (reset) model_edge();
      check_outs();
   endtask
   task automatic do_reset(input int n);
      reset = 1'b0; ms = M_RST; mdelay = 0;
      repeat (n) tick(1'b0, 1'b0, 16'd0);
      reset = 1'b1;
   endtask
   task automatic wait_exp(input string nm, input int want, input logic [15:0] r);
      int n = 0;
      while (!expired && n < 20000) begin
         tick(1'b0, 1'b0, r);
         n++;
      end
      chk(nm, 17'(n), 17'(want));
   endtask
   initial begin
      tv[0] = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 17'd0};
      tv[1] = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 17'd5};
      for (int i = 2; i < 8; i++) tv[i] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 17'd5};
      tv[4] = '{1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 17'd5};
      tv[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 17'd5};
      tv[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 17'd5};
      #2;
      do_reset(3);
      repeat (3) tick(1'b0, 1'b0, 16'h1234);
      tick(1'b1, 1'b0, 16'h0003);
      chk("arm_dv5", delay_val, 17'd5);
      wait_exp("latency_5", 20, 16'h0003);
      repeat (3) tick(1'b0, 1'b0, 16'h0003);
      tick(1'b1, 1'b0, 16'h0001);
      chk("rearm_dv3", delay_val, 17'd3);
      wait_exp("latency_3", 12, 16'h0001);
      tick(1'b1, 1'b0, 16'hFFFF);
      chk("arm_dv4097", delay_val, 17'd4097);
      wait_exp("latency_4097", 16388, 16'h0000);
      tick(1'b0, 1'b1, 16'h0000);
      do_reset(2);
      for (int i = 0; i < 10; i++) begin
         tick(tv[i].st, tv[i].cn, tv[i].r);
         chk($sformatf("tbl%0d_busy", i), 17'(busy), 17'(tv[i].b));
         chk($sformatf("tbl%0d_exp", i), 17'(expired), 17'(tv[i].e));
         chk($sformatf("tbl%0d_ld", i), 17'(lfsr_ld), 17'(tv[i].l));
         chk($sformatf("tbl%0d_dv", i), delay_val, tv[i].dv);
      end
      for (int i = 0; i < 3000; i++) begin
         tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0), 16'($urandom) & 16'hF00F);
         chk("exclusive", 17'(busy & expired), 17'd0);
      end
`ifdef EARLY_PRESS_EN
      tick(1'b0, 1'b1, 16'h0000);
      press = 1'b1;
      tick(1'b0, 1'b0, 16'h0000);
      press = 1'b0;
      tick(1'b1, 1'b0, 16'h0003);
      repeat (4) tick(1'b0, 1'b0, 16'h0000);
      press = 1'b1;
      tick(1'b0, 1'b0, 16'h0000);
      press = 1'b0;
      repeat (30) tick(1'b0, 1'b0, 16'h0000);
      tick(1'b1, 1'b0, 16'h0002);
      tick(1'b0, 1'b1, 16'h0000);
      tick(1'b0, 1'b0, 16'h0000);
`endif
      tick(1'b0, 1'b1, 16'h0000);
      tick(1'b1, 1'b0, 16'h0002);
      repeat (5) tick(1'b0, 1'b0, 16'h0000);
      #3;
      reset = 1'b0;
      #1;
      ms = M_RST; mdelay = 0;
      check_outs();
      do_reset(2);
      tick(1'b0, 1'b0, 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
